// File: rtl/stack_ctrl.sv
// Call/flag stack sequencer: arbitrates IRQ over CU, turns request/ack handshakes into
// single-cycle push/pop strobes, and tracks occupancy with sticky overflow/underflow flags.
module stack_ctrl #(
  parameter int unsigned STACK_LEN = 16,
  parameter int unsigned DEPTH_W   = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               irq_push_req,
  input  logic               irq_pop_req,
  input  logic               cu_push_req,
  input  logic               cu_pop_req,
  input  logic               err_clr,
  output logic               irq_ack,
  output logic               cu_ack,
  output logic               req_err,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               grant_irq,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty,
  output logic               ovf_err,
  output logic               unf_err
);

  localparam logic [DEPTH_W-1:0] MaxDepth = DEPTH_W'(STACK_LEN);
  localparam logic [DEPTH_W-1:0] One      = DEPTH_W'(1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q;
  logic   op_push_q;
  logic   op_bad_q;
  logic   irq_any;
  logic   cu_any;

  assign irq_any = irq_push_req | irq_pop_req;
  assign cu_any  = cu_push_req | cu_pop_req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      op_push_q <= 1'b0;
      op_bad_q  <= 1'b0;
      irq_ack   <= 1'b0;
      cu_ack    <= 1'b0;
      req_err   <= 1'b0;
      stk_push  <= 1'b0;
      stk_pop   <= 1'b0;
      grant_irq <= 1'b0;
      depth     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
    end else begin
      irq_ack  <= 1'b0;
      cu_ack   <= 1'b0;
      req_err  <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      // Clear first so a coincident error event below overrides it.
      if (err_clr) begin
        ovf_err <= 1'b0;
        unf_err <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (irq_any) begin
            grant_irq <= 1'b1;
            op_push_q <= irq_push_req;
            op_bad_q  <= irq_push_req & irq_pop_req;
            state_q   <= StExec;
          end else if (cu_any) begin
            grant_irq <= 1'b0;
            op_push_q <= cu_push_req;
            op_bad_q  <= cu_push_req & cu_pop_req;
            state_q   <= StExec;
          end
        end
        StExec: begin
          irq_ack <= grant_irq;
          cu_ack  <= ~grant_irq;
          if (op_bad_q) begin
            req_err <= 1'b1;
          end else if (op_push_q) begin
            if (depth < MaxDepth) begin
              stk_push <= 1'b1;
              depth    <= depth + One;
              full     <= (depth + One) == MaxDepth;
              empty    <= 1'b0;
            end else begin
              req_err <= 1'b1;
              ovf_err <= 1'b1;
            end
          end else begin
            if (depth != '0) begin
              stk_pop <= 1'b1;
              depth   <= depth - One;
              empty   <= depth == One;
              full    <= 1'b0;
            end else begin
              req_err <= 1'b1;
              unf_err <= 1'b1;
            end
          end
          state_q <= StDone;
        end
        StDone: begin
          // Gives the requester one cycle to drop its request.
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed scenarios plus randomized traffic checked
// against a queue-based model of the stack and its sticky flags.
module tb_stack_ctrl;

  localparam int LEN = 16;
  localparam int DW  = 5;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          irq_push_req = 1'b0, irq_pop_req = 1'b0;
  logic          cu_push_req = 1'b0, cu_pop_req = 1'b0;
  logic          err_clr = 1'b0;
  logic          irq_ack, cu_ack, req_err, stk_push, stk_pop, grant_irq;
  logic [DW-1:0] depth;
  logic          full, empty, ovf_err, unf_err;

  stack_ctrl #(.STACK_LEN(LEN), .DEPTH_W(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .irq_push_req(irq_push_req), .irq_pop_req(irq_pop_req),
    .cu_push_req(cu_push_req), .cu_pop_req(cu_pop_req),
    .err_clr(err_clr),
    .irq_ack(irq_ack), .cu_ack(cu_ack), .req_err(req_err),
    .stk_push(stk_push), .stk_pop(stk_pop), .grant_irq(grant_irq),
    .depth(depth), .full(full), .empty(empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Reference model
  int         m_depth = 0;
  bit         m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_q[$];

  // Stack memory attached to the strobes, with the grant-muxed data bus
  logic [7:0] irq_data = 8'h00, cu_data = 8'h00;
  logic [7:0] mem [LEN];
  int         sp;
  logic [7:0] DATA;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) sp <= 0;
    else if (stk_push && sp < LEN) begin
      mem[sp] <= grant_irq ? irq_data : cu_data;
      sp <= sp + 1;
    end else if (stk_pop && sp > 0) sp <= sp - 1;
  end

  always_comb begin
    DATA = 8'h00;
    if (sp > 0) DATA = mem[sp-1];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".depth"}, 32'(depth), 32'(m_depth));
    chk({tag, ".full"},  32'(full),  32'(m_depth == LEN));
    chk({tag, ".empty"}, 32'(empty), 32'(m_depth == 0));
    chk({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
    chk({tag, ".unf"},   32'(unf_err), 32'(m_unf));
  endtask

  // Strobe exclusivity and single-cycle width, checked every cycle out of reset
  logic prev_push = 1'b0, prev_pop = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      chk("strobe_excl", 32'(stk_push && stk_pop), 32'd0);
      chk("push_width",  32'(stk_push && prev_push), 32'd0);
      chk("pop_width",   32'(stk_pop && prev_pop), 32'd0);
    end
    prev_push = stk_push;
    prev_pop  = stk_pop;
  end

  // clr_mode: 0 none, 1 err_clr at the sampling edge, 2 err_clr at the execute edge
  task automatic do_op(input bit irq, input bit push, input bit pop, input logic [7:0] data,
                       input int clr_mode, input string tag);
    bit         both;
    bit         e_push, e_pop;
    logic [7:0] e_data;
    int         n;
    both   = push && pop;
    e_data = 8'h00;
    @(negedge CLK);
    if (irq) begin
      irq_data = data; irq_push_req = push; irq_pop_req = pop;
    end else begin
      cu_data = data; cu_push_req = push; cu_pop_req = pop;
    end
    err_clr = (clr_mode == 1);
    @(posedge CLK); #1;
    err_clr = (clr_mode == 2);
    n = 1;
    while (!(irq_ack || cu_ack) && n < 8) begin
      @(posedge CLK); #1;
      n++;
    end
    err_clr = 1'b0;
    if (clr_mode != 0) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    e_push = !both && push && m_depth < LEN;
    e_pop  = !both && pop && m_depth > 0;
    if (!both && push && !e_push) m_ovf = 1'b1;
    if (!both && pop && !e_pop) m_unf = 1'b1;
    if (e_push) begin
      m_q.push_back(data);
      m_depth++;
    end
    if (e_pop) begin
      e_data = m_q.pop_back();
      m_depth--;
    end
    chk({tag, ".latency"}, 32'(n), 32'd2);
    chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(irq));
    chk({tag, ".cu_ack"},  32'(cu_ack), 32'(!irq));
    chk({tag, ".grant"},   32'(grant_irq), 32'(irq));
    chk({tag, ".req_err"}, 32'(req_err), 32'(!(e_push || e_pop)));
    chk({tag, ".push"},    32'(stk_push), 32'(e_push));
    chk({tag, ".pop"},     32'(stk_pop), 32'(e_pop));
    if (e_pop) chk({tag, ".data"}, 32'(DATA), 32'(e_data));
    check_regs(tag);
    irq_push_req = 1'b0; irq_pop_req = 1'b0;
    cu_push_req = 1'b0; cu_pop_req = 1'b0;
    @(posedge CLK); #1;
    chk({tag, ".quiet"}, 32'({irq_ack, cu_ack, stk_push, stk_pop}), 32'd0);
    chk({tag, ".grant_hold"}, 32'(grant_irq), 32'(irq));
  endtask

  task automatic clear_flags(input string tag);
    @(negedge CLK);
    err_clr = 1'b1;
    @(posedge CLK); #1;
    err_clr = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_regs(tag);
  endtask

  initial begin
    int n;
    int r;

    // Reset values
    #12;
    chk("rst.outs", 32'({irq_ack, cu_ack, req_err, stk_push, stk_pop, grant_irq}), 32'd0);
    check_regs("rst");
    @(negedge CLK);
    RESET = 1'b1;

    // Pop from empty
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 0, "pop_empty");
    clear_flags("clr_unf");

    // Three CU pushes
    for (int i = 0; i < 3; i++) do_op(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 0, "cu_push");

    // Simultaneous IRQ and CU push: IRQ first, CU one op later
    @(negedge CLK);
    irq_data = 8'h3C; cu_data = 8'hC3;
    irq_push_req = 1'b1; cu_push_req = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(irq_ack || cu_ack) && n < 8);
    chk("arb.irq_lat", 32'(n), 32'd2);
    chk("arb.irq_ack", 32'({irq_ack, cu_ack, grant_irq, stk_push}), 32'b1011);
    m_q.push_back(8'h3C); m_depth++;
    irq_push_req = 1'b0;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!(irq_ack || cu_ack) && n < 8);
    chk("arb.cu_gap", 32'(n), 32'd3);
    chk("arb.cu_ack", 32'({irq_ack, cu_ack, grant_irq, stk_push}), 32'b0101);
    m_q.push_back(8'hC3); m_depth++;
    cu_push_req = 1'b0;
    @(posedge CLK); #1;
    check_regs("arb");

    // Fill, overflow, clear; then set-wins on a coincident clear
    while (m_depth < LEN) do_op(1'(m_depth % 2), 1'b1, 1'b0, 8'($urandom), 0, "fill");
    do_op(1'b0, 1'b1, 1'b0, 8'hEE, 0, "ovf");
    clear_flags("clr_ovf");
    do_op(1'b1, 1'b1, 1'b0, 8'hEE, 2, "ovf_setwins");
    clear_flags("clr_ovf2");

    // Protocol error: push and pop together
    do_op(1'b1, 1'b1, 1'b1, 8'h00, 0, "proto");

    // Drain, then pop data check
    while (m_depth > 0) do_op(1'b0, 1'b0, 1'b1, 8'h00, 0, "drain");
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 2, "unf_setwins");
    clear_flags("clr_unf2");
    do_op(1'b0, 1'b1, 1'b0, 8'h11, 0, "pd_push");
    do_op(1'b0, 1'b1, 1'b0, 8'hA5, 0, "pd_push");
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 0, "pd_pop");
    do_op(1'b0, 1'b0, 1'b1, 8'h00, 0, "pd_pop");

    // Reset during a push strobe
    @(negedge CLK);
    cu_data = 8'h77; cu_push_req = 1'b1;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
    end while (!stk_push && n < 8);
    chk("rstmid.strobe", 32'(stk_push), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rstmid.drop", 32'({stk_push, stk_pop, cu_ack, irq_ack, req_err}), 32'd0);
    cu_push_req = 1'b0;
    m_depth = 0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_regs("rstmid");
    @(negedge CLK);
    RESET = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      chk("rstmid.noack", 32'({stk_push, stk_pop, cu_ack, irq_ack}), 32'd0);
    end
    check_regs("rstmid.after");

    // Randomized traffic
    repeat (80) begin
      r = int'($urandom_range(0, 9));
      do_op(1'($urandom_range(0, 1)), r < 5 || r == 9, r >= 5, 8'($urandom),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequences the hardware call/flag stack and shares it between two requesters: the interrupt unit (IRQ) and the control unit (CU, CALL/RET).
- Converts request/acknowledge handshakes into single-cycle push and pop strobes.
- Tracks occupancy and flags overflow and underflow; refused operations never reach the stack.
- Drives the grant select that muxes the winning requester onto the stack DATA/flag bus.

Parameters:
- STACK_LEN, 16, stack capacity in entries.
- DEPTH_W, 5, width of the depth counter; must hold 0..STACK_LEN.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous reset, active-low.
- irq_push_req  input  1  IRQ requests a push (save PC+flags).
- irq_pop_req  input  1  IRQ requests a pop (RETI).
- cu_push_req  input  1  CU requests a push (CALL).
- cu_pop_req  input  1  CU requests a pop (RET).
- irq_ack  output  1  one-cycle acknowledge to IRQ.
- cu_ack  output  1  one-cycle acknowledge to CU.
- req_err  output  1  qualifies ack: operation refused, no stack access.
- stk_push  output  1  push strobe to stack (stores DATA+flag).
- stk_pop  output  1  pop strobe to stack (stack drives DATA+flag).
- grant_irq  output  1  1 = IRQ owns the stack bus, 0 = CU.
- depth  output  DEPTH_W  current occupancy.
- full  output  1  depth == STACK_LEN.
- empty  output  1  depth == 0.
- ovf_err  output  1  sticky overflow flag.
- unf_err  output  1  sticky underflow flag.
- err_clr  input  1  synchronous clear of ovf_err and unf_err.

Behaviour:
- Reset (RESET low, async): all outputs 0 except empty = 1. FSM state = IDLE, depth = 0, grant_irq = 0. Asserting reset mid-operation drops stk_push, stk_pop and all acks immediately; the pending operation is lost.
- All outputs are registered; full and empty decode the registered depth.
- FSM states: IDLE, EXEC, DONE.
- IDLE: sample requests. IRQ has fixed priority over CU; an IRQ request present in the same cycle as a CU request wins. On any request, latch the winner into grant_irq and the operation (push/pop) -> EXEC. With no request, remain in IDLE; grant_irq holds its last value.
- EXEC (one cycle), legal push (depth < STACK_LEN): stk_push = 1, depth+1.
- EXEC, legal pop (depth > 0): stk_pop = 1, depth-1. Pop data is valid on the bus during this cycle.
- EXEC, winner's ack = 1 for this same cycle; the requester captures pop data on this edge. Next state DONE.
- Push when full: no strobe, depth unchanged, ack = 1 with req_err = 1, ovf_err set.
- Pop when empty: no strobe, ack = 1 with req_err = 1, unf_err set.
- Push and pop both asserted by one requester is a protocol error: ack with req_err = 1, no strobe, sticky flags unchanged.
- DONE (one cycle): no strobes and no acks -> IDLE. This gives the requester one cycle to drop its request. A request still high when the FSM returns to IDLE is a new request.
- Throughput: one operation per 3 cycles. Latency from request to ack/strobe is 2 cycles.
- grant_irq is stable from EXEC through DONE; the bus mux must not glitch during a strobe.
- Strobes are exclusive: stk_push and stk_pop are never high together, and each is never high for more than one cycle.
- Sticky flags: ovf_err and unf_err hold until err_clr. If err_clr coincides with a new error event, set wins.
- Depth saturates within 0..STACK_LEN by construction and never wraps.

Test Plan:
- Reset, then 3 CU pushes -> each cu_ack exactly 2 cycles after req; 3 stk_push pulses; depth = 3; empty = 0; grant_irq = 0.
- IRQ and CU push requests raised in the same cycle -> IRQ served first (grant_irq = 1, irq_ack); CU served one op later (3 cycles later); depth +2.
- 16 pushes, then a 17th push -> 17th: ack with req_err = 1, no stk_push, ovf_err = 1, full = 1, depth = 16. Then err_clr -> ovf_err = 0.
- Pop from reset (empty) -> cu_ack with req_err = 1, no stk_pop, unf_err = 1, depth = 0.
- Push 2, pop 2 with pop data 0xA5 preloaded on the stack model -> stk_pop and cu_ack coincide with 0xA5 on DATA; depth returns to 0; empty = 1.
- Assert RESET while the FSM is in EXEC of a push -> stk_push falls asynchronously; depth = 0; FSM in IDLE; no ack after release.
